// File: rtl/corner_stabilizer.sv
// corner_stabilizer
//   Turns the per-frame corner finder output into a steady set of corner
//   addresses for the warp/overlay stage.
//   Processing happens once per frame:
//   - lock acquisition over LOCK_FRAMES consecutive successful frames;
//   - per-coordinate IIR smoothing, with large jumps snapped straight to the input;
//   - coasting on the last published corners for up to MAX_MISS missed frames;
//   - falling back to the full-frame default corners after that.
//
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_frame_valid         frame-done level; only its rising edge starts a frame
//   i_success             the finder saw enough foreground in this frame
//   i_{ul,ur,dl,dr}_addr  raw corners, {row[19:10], col[9:0]}
//   o_{ul,ur,dl,dr}_addr  stabilised corners, same format
//   o_locked              tracking locked (held while coasting)
//   o_update              one-cycle pulse in the cycle the o_*_addr values are refreshed
module corner_stabilizer #(
    parameter int ALPHA_SHIFT = 2,
    parameter int JUMP_TH     = 64,
    parameter int LOCK_FRAMES = 2,
    parameter int MAX_MISS    = 8,
    parameter int ROW_MAX     = 599,
    parameter int COL_MAX     = 799
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_frame_valid,
    input  logic        i_success,
    input  logic [19:0] i_ul_addr,
    input  logic [19:0] i_ur_addr,
    input  logic [19:0] i_dl_addr,
    input  logic [19:0] i_dr_addr,
    output logic [19:0] o_ul_addr,
    output logic [19:0] o_ur_addr,
    output logic [19:0] o_dl_addr,
    output logic [19:0] o_dr_addr,
    output logic        o_locked,
    output logic        o_update
);

    typedef enum logic [1:0] {P_IDLE, P_CALC, P_COMMIT} proc_state_t;
    typedef enum logic [1:0] {UNLOCK, ACQ, LOCKED} track_state_t;

    localparam logic [9:0]         ROW_LAST = 10'(ROW_MAX);
    localparam logic [9:0]         COL_LAST = 10'(COL_MAX);
    localparam logic signed [10:0] JUMP_LIM = 11'(JUMP_TH);
    localparam logic [3:0]         LOCK_CNT = 4'(LOCK_FRAMES);
    localparam logic [3:0]         MISS_CNT = 4'(MAX_MISS);

    localparam logic [19:0] DEF_UL = {10'd0, 10'd0};
    localparam logic [19:0] DEF_UR = {10'd0, COL_LAST};
    localparam logic [19:0] DEF_DL = {ROW_LAST, 10'd0};
    localparam logic [19:0] DEF_DR = {ROW_LAST, COL_LAST};

    // Working coordinates, slot k in processing order:
    // 0 ul.row, 1 ul.col, 2 ur.row, 3 ur.col, 4 dl.row, 5 dl.col, 6 dr.row, 7 dr.col
    localparam logic [7:0][9:0] DEF_WORK =
        {COL_LAST, ROW_LAST, 10'd0, ROW_LAST, COL_LAST, 10'd0, 10'd0, 10'd0};

    // One coordinate step: snap on large jumps (or when snapping is forced),
    // otherwise move a 1/2^ALPHA_SHIFT fraction of the way, at least one unit.
    // The step never overshoots the input, so the 10-bit result stays in range.
    function automatic logic [9:0] filter_coord(input logic [9:0] in_v,
                                                input logic [9:0] work_v,
                                                input logic       snap);
        logic signed [10:0] d;
        logic signed [10:0] mag;
        logic signed [10:0] s;
        d   = $signed({1'b0, in_v}) - $signed({1'b0, work_v});
        mag = d[10] ? -d : d;
        if (snap || (mag >= JUMP_LIM)) begin
            return in_v;
        end
        s = d >>> ALPHA_SHIFT;
        if ((s == 11'sd0) && (d != 11'sd0)) begin
            s = d[10] ? -11'sd1 : 11'sd1;
        end
        return work_v + s[9:0];
    endfunction

    proc_state_t      proc_state;
    track_state_t     track_state;
    logic [2:0]       coord_idx;
    logic             frame_valid_d;
    logic [3:0]       acq_cnt;
    logic [3:0]       miss_cnt;
    logic [7:0][9:0]  work;

    logic [3:0][19:0] cap_addr;
    logic             cap_success;

    logic             frame_accept;
    logic [19:0]      cap_sel;
    logic [9:0]       coord_in;
    logic [9:0]       coord_new;
    logic [19:0]      work_ul;
    logic [19:0]      work_ur;
    logic [19:0]      work_dl;
    logic [19:0]      work_dr;

    // Rising edges that arrive while a frame is still in flight are ignored.
    assign frame_accept = i_frame_valid && !frame_valid_d && (proc_state == P_IDLE);

    assign work_ul = {work[0], work[1]};
    assign work_ur = {work[2], work[3]};
    assign work_dl = {work[4], work[5]};
    assign work_dr = {work[6], work[7]};

    // Frame capture: held stable for the whole calculation.
    always_ff @(posedge i_clk) begin
        if (frame_accept) begin
            cap_addr    <= {i_dr_addr, i_dl_addr, i_ur_addr, i_ul_addr};
            cap_success <= i_success;
        end
    end

    // Shared datapath: one coordinate per P_CALC cycle. Until locked, every
    // coordinate snaps to the input.
    always_comb begin
        cap_sel   = cap_addr[coord_idx[2:1]];
        coord_in  = coord_idx[0] ? cap_sel[9:0] : cap_sel[19:10];
        coord_new = filter_coord(coord_in, work[coord_idx], track_state != LOCKED);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            proc_state    <= P_IDLE;
            track_state   <= UNLOCK;
            coord_idx     <= 3'd0;
            frame_valid_d <= 1'b0;
            acq_cnt       <= 4'd0;
            miss_cnt      <= 4'd0;
            work          <= DEF_WORK;
            o_ul_addr     <= DEF_UL;
            o_ur_addr     <= DEF_UR;
            o_dl_addr     <= DEF_DL;
            o_dr_addr     <= DEF_DR;
            o_locked      <= 1'b0;
            o_update      <= 1'b0;
        end else begin
            frame_valid_d <= i_frame_valid;
            o_update      <= 1'b0;

            case (proc_state)
                P_IDLE: begin
                    if (frame_accept) begin
                        proc_state <= P_CALC;
                        coord_idx  <= 3'd0;
                    end
                end

                // A missed frame leaves the working set untouched so that
                // coasting resumes filtering from the last good corners.
                P_CALC: begin
                    if (cap_success) begin
                        work[coord_idx] <= coord_new;
                    end
                    coord_idx <= coord_idx + 3'd1;
                    if (coord_idx == 3'd7) begin
                        proc_state <= P_COMMIT;
                    end
                end

                P_COMMIT: begin
                    proc_state <= P_IDLE;
                    case (track_state)
                        UNLOCK: begin
                            if (cap_success) begin
                                if (LOCK_CNT == 4'd1) begin
                                    track_state <= LOCKED;
                                    acq_cnt     <= 4'd0;
                                    miss_cnt    <= 4'd0;
                                    o_ul_addr   <= work_ul;
                                    o_ur_addr   <= work_ur;
                                    o_dl_addr   <= work_dl;
                                    o_dr_addr   <= work_dr;
                                    o_locked    <= 1'b1;
                                    o_update    <= 1'b1;
                                end else begin
                                    track_state <= ACQ;
                                    acq_cnt     <= 4'd1;
                                end
                            end
                        end

                        ACQ: begin
                            if (!cap_success) begin
                                track_state <= UNLOCK;
                                acq_cnt     <= 4'd0;
                            end else if (acq_cnt + 4'd1 == LOCK_CNT) begin
                                track_state <= LOCKED;
                                acq_cnt     <= 4'd0;
                                miss_cnt    <= 4'd0;
                                o_ul_addr   <= work_ul;
                                o_ur_addr   <= work_ur;
                                o_dl_addr   <= work_dl;
                                o_dr_addr   <= work_dr;
                                o_locked    <= 1'b1;
                                o_update    <= 1'b1;
                            end else begin
                                acq_cnt <= acq_cnt + 4'd1;
                            end
                        end

                        LOCKED: begin
                            if (cap_success) begin
                                miss_cnt  <= 4'd0;
                                o_ul_addr <= work_ul;
                                o_ur_addr <= work_ur;
                                o_dl_addr <= work_dl;
                                o_dr_addr <= work_dr;
                                o_update  <= 1'b1;
                            end else if (miss_cnt + 4'd1 == MISS_CNT) begin
                                // Coasting budget exhausted: fall back to the full frame.
                                track_state <= UNLOCK;
                                miss_cnt    <= 4'd0;
                                work        <= DEF_WORK;
                                o_ul_addr   <= DEF_UL;
                                o_ur_addr   <= DEF_UR;
                                o_dl_addr   <= DEF_DL;
                                o_dr_addr   <= DEF_DR;
                                o_locked    <= 1'b0;
                                o_update    <= 1'b1;
                            end else begin
                                miss_cnt <= miss_cnt + 4'd1;
                            end
                        end

                        default: begin
                            track_state <= UNLOCK;
                        end
                    endcase
                end

                default: begin
                    proc_state <= P_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_corner_stabilizer.sv
`timescale 1ns/1ps
module tb_corner_stabilizer;

    localparam int ALPHA_SHIFT = 2;
    localparam int JUMP_TH     = 64;
    localparam int LOCK_FRAMES = 2;
    localparam int MAX_MISS    = 8;
    localparam int ROW_MAX     = 599;
    localparam int COL_MAX     = 799;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        fv    = 1'b0;
    logic        succ  = 1'b0;
    logic [19:0] ul    = 20'd0;
    logic [19:0] ur    = 20'd0;
    logic [19:0] dl    = 20'd0;
    logic [19:0] dr    = 20'd0;
    logic [19:0] o_ul, o_ur, o_dl, o_dr;
    logic        o_locked, o_update;

    int total  = 0;
    int bad    = 0;
    int pulses = 0;

    always #5 clk = ~clk;

    corner_stabilizer #(
        .ALPHA_SHIFT(ALPHA_SHIFT), .JUMP_TH(JUMP_TH), .LOCK_FRAMES(LOCK_FRAMES),
        .MAX_MISS(MAX_MISS), .ROW_MAX(ROW_MAX), .COL_MAX(COL_MAX)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_frame_valid(fv), .i_success(succ),
        .i_ul_addr(ul), .i_ur_addr(ur), .i_dl_addr(dl), .i_dr_addr(dr),
        .o_ul_addr(o_ul), .o_ur_addr(o_ur), .o_dl_addr(o_dl), .o_dr_addr(o_dr),
        .o_locked(o_locked), .o_update(o_update)
    );

    function automatic logic [19:0] a(input int r, input int c);
        return {r[9:0], c[9:0]};
    endfunction

    function automatic logic [19:0] def_addr(input int i);
        case (i)
            0:       return a(0, 0);
            1:       return a(0, COL_MAX);
            2:       return a(ROW_MAX, 0);
            default: return a(ROW_MAX, COL_MAX);
        endcase
    endfunction

    function automatic int coord_of(input logic [19:0] ad, input int k);
        return (k % 2 == 0) ? int'(ad[19:10]) : int'(ad[9:0]);
    endfunction

    task automatic chk(input string nm, input logic [19:0] act, input logic [19:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%05h want=0x%05h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int          m_state;        // 0 unlocked, 1 acquiring, 2 locked
    int          m_acq, m_miss;
    int          m_wk[8];
    logic [19:0] m_pub[4];
    logic        m_lock;
    logic [19:0] nx_o[4];
    logic        nx_lock, nx_pulse;
    logic [19:0] exp_o[4];
    logic        exp_lock, exp_upd;
    bit          pend;
    int          pend_cyc, idle_from, cyc;
    logic        prev_fv;

    function automatic int mfilt(input int inv, input int w);
        int d, s;
        d = inv - w;
        if (d >= JUMP_TH || d <= -JUMP_TH) return inv;
        s = d >>> ALPHA_SHIFT;
        if (s == 0 && d != 0) s = (d > 0) ? 1 : -1;
        return w + s;
    endfunction

    task automatic model_defaults();
        for (int i = 0; i < 4; i++) m_pub[i] = def_addr(i);
        for (int k = 0; k < 8; k++) m_wk[k] = coord_of(def_addr(k / 2), k);
    endtask

    task automatic model_reset();
        model_defaults();
        m_state = 0; m_acq = 0; m_miss = 0; m_lock = 1'b0;
        for (int i = 0; i < 4; i++) exp_o[i] = def_addr(i);
        exp_lock = 1'b0; exp_upd = 1'b0;
        pend = 0; idle_from = 0; prev_fv = 1'b0;
    endtask

    task automatic model_publish();
        for (int c = 0; c < 4; c++) m_pub[c] = a(m_wk[2 * c], m_wk[2 * c + 1]);
        nx_pulse = 1'b1;
    endtask

    task automatic model_event(input logic s, input logic [19:0] in_a[4]);
        int inv[8];
        for (int k = 0; k < 8; k++) inv[k] = coord_of(in_a[k / 2], k);
        nx_pulse = 1'b0;
        if (s) begin
            if (m_state == 2) begin
                for (int k = 0; k < 8; k++) m_wk[k] = mfilt(inv[k], m_wk[k]);
                m_miss = 0;
                model_publish();
            end else begin
                for (int k = 0; k < 8; k++) m_wk[k] = inv[k];
                m_acq = (m_state == 0) ? 1 : m_acq + 1;
                if (m_acq >= LOCK_FRAMES) begin
                    m_state = 2; m_lock = 1'b1; m_miss = 0;
                    model_publish();
                end else begin
                    m_state = 1;
                end
            end
        end else if (m_state == 1) begin
            m_state = 0; m_acq = 0;
        end else if (m_state == 2) begin
            m_miss++;
            if (m_miss == MAX_MISS) begin
                m_state = 0; m_miss = 0; m_lock = 1'b0;
                model_defaults();
                nx_pulse = 1'b1;
            end
        end
        nx_o = m_pub;
        nx_lock = m_lock;
    endtask

    // A frame seen at the edge closing cycle t becomes visible in cycle t+10;
    // no new frame is taken before cycle t+10.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            logic [19:0] in_a[4];
            exp_upd = 1'b0;
            if (pend && cyc == pend_cyc) begin
                exp_o = nx_o; exp_lock = nx_lock; exp_upd = nx_pulse; pend = 0;
            end
            if (fv && !prev_fv && cyc >= idle_from) begin
                in_a[0] = ul; in_a[1] = ur; in_a[2] = dl; in_a[3] = dr;
                model_event(succ, in_a);
                pend = 1; pend_cyc = cyc + 9; idle_from = cyc + 10;
            end
            prev_fv = fv;
            cyc++;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("model_ul", o_ul, exp_o[0]);
        chk("model_ur", o_ur, exp_o[1]);
        chk("model_dl", o_dl, exp_o[2]);
        chk("model_dr", o_dr, exp_o[3]);
        chk("model_locked", 20'(o_locked), 20'(exp_lock));
        chk("model_update", 20'(o_update), 20'(exp_upd));
    end

    always @(posedge clk) begin
        #1;
        if (o_update === 1'b1) pulses++;
    end

    // ---------------- stimulus ----------------
    localparam logic [19:0] URF = 20'h19258;  // {100,600}
    localparam logic [19:0] DLF = 20'h7d0c8;  // {500,200}
    localparam logic [19:0] DRF = 20'h7d258;  // {500,600}

    logic upd_t9;

    // Starts a frame at cycle t; returns while sampling cycle t+10.
    task automatic send_frame(input logic s, input logic [19:0] a_ul);
        @(negedge clk);
        ul = a_ul; ur = URF; dl = DLF; dr = DRF; succ = s; fv = 1'b1;
        @(negedge clk);
        fv = 1'b0;
        repeat (7) @(negedge clk);
        @(negedge clk);
        upd_t9 = o_update;
        @(negedge clk);
    endtask

    function automatic int clampv(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    function automatic int jit();
        if ($urandom_range(0, 99) < 10) return int'($urandom_range(0, 200)) - 100;
        return int'($urandom_range(0, 24)) - 12;
    endfunction

    initial begin
        int p0, br, bc;
        model_reset();
        cyc = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 1: idle after reset
        repeat (20) @(negedge clk);
        chk("rst_ul", o_ul, 20'h00000);
        chk("rst_ur", o_ur, a(0, 799));
        chk("rst_dl", o_dl, a(599, 0));
        chk("rst_dr", o_dr, a(599, 799));
        chk("rst_locked", 20'(o_locked), 20'd0);
        chk("rst_no_pulse", 20'(pulses), 20'd0);

        // 2: acquisition over two frames
        send_frame(1'b1, a(100, 200));
        chk("acq1_no_pulse", 20'(pulses), 20'd0);
        chk("acq1_unlocked", 20'(o_locked), 20'd0);
        send_frame(1'b1, a(100, 200));
        chk("lock_t9_quiet", 20'(upd_t9), 20'd0);
        chk("lock_t10_pulse", 20'(o_update), 20'd1);
        chk("lock_ul", o_ul, a(100, 200));
        chk("lock_locked", 20'(o_locked), 20'd1);

        // 3: smoothing
        send_frame(1'b1, a(108, 200)); chk("iir_108", o_ul, a(102, 200));
        send_frame(1'b1, a(96, 200));  chk("iir_96", o_ul, a(100, 200));
        send_frame(1'b1, a(101, 200)); chk("iir_101", o_ul, a(101, 200));
        send_frame(1'b1, a(101, 200));
        chk("iir_same", o_ul, a(101, 200));
        chk("iir_same_pulse", 20'(o_update), 20'd1);

        // 4: jump snapping
        send_frame(1'b1, a(100, 200)); chk("step_m1", o_ul, a(100, 200));
        send_frame(1'b1, a(300, 200)); chk("snap_up", o_ul, a(300, 200));
        send_frame(1'b1, a(163, 200)); chk("snap_dn", o_ul, a(163, 200));
        send_frame(1'b1, a(200, 200)); chk("iir_37", o_ul, a(172, 200));

        // 5: coasting and timeout
        for (int i = 0; i < 7; i++) begin
            send_frame(1'b0, a(10, 10));
            chk("coast_no_pulse", 20'(o_update), 20'd0);
            chk("coast_locked", 20'(o_locked), 20'd1);
            chk("coast_hold", o_ul, a(172, 200));
        end
        send_frame(1'b1, a(172, 200));
        chk("coast_resume", 20'(o_update), 20'd1);
        for (int i = 0; i < 8; i++) begin
            send_frame(1'b0, a(10, 10));
            chk("timeout_pulse", 20'(o_update), 20'((i == 7) ? 1 : 0));
            chk("timeout_locked", 20'(o_locked), 20'((i == 7) ? 0 : 1));
        end
        chk("timeout_ul", o_ul, a(0, 0));
        chk("timeout_dr", o_dr, a(599, 799));

        // 6: level held, dropped edge, reset mid-frame
        send_frame(1'b1, a(100, 200));
        send_frame(1'b1, a(100, 200));
        chk("relock", 20'(o_locked), 20'd1);
        p0 = pulses;
        @(negedge clk); ul = a(100, 200); succ = 1'b1; fv = 1'b1;
        repeat (4) @(negedge clk);
        fv = 1'b0;
        repeat (14) @(negedge clk);
        chk("hold5_one_event", 20'(pulses - p0), 20'd1);

        p0 = pulses;
        @(negedge clk); ul = a(110, 200); fv = 1'b1;
        repeat (3) @(negedge clk);
        fv = 1'b0;
        @(negedge clk); ul = a(400, 200); fv = 1'b1;
        @(negedge clk); fv = 1'b0;
        repeat (10) @(negedge clk);
        chk("drop_one_pulse", 20'(pulses - p0), 20'd1);
        chk("drop_ul", o_ul, a(102, 200));

        p0 = pulses;
        @(negedge clk); ul = a(50, 200); fv = 1'b1;
        repeat (3) @(negedge clk);
        fv = 1'b0;
        @(negedge clk); ul = a(450, 100); fv = 1'b1;
        @(negedge clk); fv = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ul", o_ul, a(0, 0));
        chk("arst_dr", o_dr, a(599, 799));
        chk("arst_locked", 20'(o_locked), 20'd0);
        chk("arst_update", 20'(o_update), 20'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("arst_no_publish", 20'(pulses - p0), 20'd0);
        chk("arst_ul_after", o_ul, a(0, 0));

        // random traffic: mostly-success, then mostly-miss with a reset
        br = 300; bc = 200;
        for (int ph = 0; ph < 2; ph++) begin
            for (int n = 0; n < 2500; n++) begin
                @(negedge clk);
                if (ph == 1 && n == 1200) begin
                    #2 rst_n = 1'b0;
                    @(negedge clk);
                    rst_n = 1'b1;
                end
                if ($urandom_range(0, 99) < 25) fv = ~fv;
                if ($urandom_range(0, 99) < 2) begin
                    br = int'($urandom_range(20, 260));
                    bc = int'($urandom_range(20, 360));
                end
                succ = ($urandom_range(0, 99) < ((ph == 0) ? 75 : 30));
                ul = a(clampv(br + jit(), ROW_MAX), clampv(bc + jit(), COL_MAX));
                ur = a(clampv(br + jit(), ROW_MAX), clampv(bc + 400 + jit(), COL_MAX));
                dl = a(clampv(br + 300 + jit(), ROW_MAX), clampv(bc + jit(), COL_MAX));
                dr = a(clampv(br + 300 + jit(), ROW_MAX), clampv(bc + 400 + jit(), COL_MAX));
            end
        end
        fv = 1'b0;
        repeat (15) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
